dcs_phase_sequencer: RTL
========================

// Module: dcs_phase_sequencer
// PURPOSE
//  Frame-level controller for the Gram/RAT/weight-multiply datapath.
//  - Counts input beats and weight beats.
//  - Issues the one-cycle w_ready request.
//  - Drives the datapath phase strobes: load, RAT threshold, accumulator clear/enable, output index, clear.
//  - Frames output words with o_valid.
//  The datapath holds no control state: it obeys only these strobes and indices.
// PARAMETERS
//  ROWS      8   rows of the input matrix; also the weight and output word count
//  COLS      16  input bytes per row
//  PIPE_LAT  2   datapath cycles from an accepted beat to its result being settled
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   asynchronous, active-low reset
//  i_valid      in   1   input byte beat from host
//  w_valid      in   1   weight byte beat from host
//  w_ready      out  1   one-cycle request for the weight vector
//  o_valid      out  1   output word valid; datapath drives o_data
//  dp_load_en   out  1   capture/accumulate the current input byte
//  dp_row_idx   out  3   row of the current input beat ($clog2(ROWS))
//  dp_col_idx   out  4   column of the current input beat ($clog2(COLS))
//  dp_rat_en    out  1   apply the row-average threshold to H (one cycle)
//  dp_acc_clr   out  1   zero the output accumulators
//  dp_acc_en    out  1   accumulate H[:,dp_w_idx]*w for the current weight beat
//  dp_w_idx     out  3   index of the current weight beat
//  dp_out_idx   out  3   accumulator selected onto o_data
//  dp_clear     out  1   zero H and the input buffer (one cycle)
//  frame_done   out  1   one-cycle pulse when a frame completes
//  err_beat     out  1   one-cycle pulse when a beat arrives in an illegal state; that beat is ignored
// BEHAVIOUR
//  Reset: every output is 0, state=IDLE, all counters 0. Reset applies immediately at any point, including mid-frame.
//  States:
//   IDLE -> LOAD       on i_valid; this beat is beat 0.
//   LOAD -> LFLUSH     on acceptance of beat ROWS*COLS-1. Gaps in i_valid are allowed.
//   LFLUSH -> RAT      after PIPE_LAT cycles.
//   RAT -> WREQ        after 1 cycle.
//   WREQ -> WLOAD      after 1 cycle.
//   WLOAD -> WFLUSH    on w_valid beat ROWS-1.
//   WFLUSH -> DRAIN    after PIPE_LAT cycles.
//   DRAIN -> CLEAR     after ROWS cycles.
//   CLEAR -> IDLE      after 1 cycle.
//  Input beat k (IDLE/LOAD with i_valid):
//   - dp_load_en=1
//   - dp_row_idx=k/COLS, dp_col_idx=k%COLS (combinational from the beat counter)
//  RAT: dp_rat_en=1 for exactly one cycle.
//  WREQ: w_ready=1 and dp_acc_clr=1 for exactly one cycle.
//  WLOAD:
//   - Each w_valid gives dp_acc_en=1 with dp_w_idx equal to the weight beat count.
//   - Gaps are allowed.
//  DRAIN: o_valid=1 on each cycle; dp_out_idx=0..ROWS-1 in order, no gaps.
//  CLEAR: dp_clear=1 and frame_done=1 for one cycle.
//  Latency:
//   - Last input beat at cycle T: w_ready at T+PIPE_LAT+2.
//   - Last weight beat at cycle U: o_valid spans U+PIPE_LAT+1 .. U+PIPE_LAT+ROWS, and frame_done follows.
//  Illegal beats:
//   - i_valid outside IDLE/LOAD: err_beat=1 for one cycle, beat ignored, counters unchanged.
//   - w_valid outside WLOAD, including the WREQ cycle itself: err_beat=1 for one cycle, beat ignored, counters unchanged.
//  Simultaneous i_valid and w_valid: each is judged by its own rule, and one err_beat pulse covers both.
//  Counters reset on entry to IDLE, so back-to-back frames need no idle gap beyond the CLEAR cycle.
//  Strobes are registered-state decodes. Only the idx outputs and dp_load_en/dp_acc_en depend combinationally on the beat inputs.
// TESTING
//  1. Frame: 128 contiguous i_valid beats (last beat T=127).
//     -> dp_row_idx steps 0..7 every 16 beats; dp_rat_en at 130; w_ready at 131 only.
//  2. Weights: w_valid at 133..140.
//     -> dp_w_idx 0..7; o_valid at 143..150 with dp_out_idx 0..7; dp_clear/frame_done at 151.
//  3. Gapped beats: i_valid every other cycle, and one 5-cycle gap within the weights.
//     -> counts, indices and latencies are unchanged relative to the last beat.
//  4. Illegal beats: i_valid during DRAIN, and w_valid in the WREQ cycle.
//     -> err_beat pulses once for each; o_valid sequence unaltered; 8 weights are still needed.
//  5. Reset: assert rst_n=0 during WLOAD after 3 weights.
//     -> all outputs 0 immediately; the next frame starts clean with beat 0 at row 0, col 0.
//  6. Back-to-back: i_valid in the cycle after CLEAR.
//     -> accepted as beat 0 of a new frame, no err_beat.

Source files
------------

// File: rtl/dcs_phase_sequencer.sv
// dcs_phase_sequencer
//   Frame-level controller for the Gram/RAT/weight-multiply datapath. The
//   sequencer does the following:
//   - counts input beats and weight beats
//   - issues the one-cycle weight request
//   - drives every datapath phase strobe and index
//   - frames the output words with o_valid
//   The datapath keeps no control state of its own.
//
// Parameters
//   ROWS      rows of the input matrix; also the weight and output word count
//   COLS      input bytes per row
//   PIPE_LAT  datapath cycles from an accepted beat to its settled result (>= 1)
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   i_valid      input byte beat from host
//   w_valid      weight byte beat from host
//   w_ready      one-cycle request for the weight vector
//   o_valid      output word valid (datapath drives the data)
//   dp_load_en   capture/accumulate the current input byte
//   dp_row_idx   row of the current input beat
//   dp_col_idx   column of the current input beat
//   dp_rat_en    apply the row-average threshold (one cycle)
//   dp_acc_clr   zero the output accumulators
//   dp_acc_en    accumulate for the current weight beat
//   dp_w_idx     index of the current weight beat
//   dp_out_idx   accumulator selected onto the output data
//   dp_clear     zero H and the input buffer (one cycle)
//   frame_done   one-cycle pulse when a frame completes
//   err_beat     one-cycle pulse after a beat arrives in an illegal state
module dcs_phase_sequencer #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 16,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_valid,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  output logic                                  o_valid,
  output logic                                  dp_load_en,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] dp_row_idx,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] dp_col_idx,
  output logic                                  dp_rat_en,
  output logic                                  dp_acc_clr,
  output logic                                  dp_acc_en,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] dp_w_idx,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] dp_out_idx,
  output logic                                  dp_clear,
  output logic                                  frame_done,
  output logic                                  err_beat
);

  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW  = (COLS > 1) ? $clog2(COLS) : 1;
  // Phase counter covers both the flush waits and the drain sweep.
  localparam int unsigned PhMax = (ROWS > PIPE_LAT) ? ROWS : PIPE_LAT;
  localparam int unsigned PhW   = $clog2(PhMax + 1);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StLoad   = 4'd1;
  localparam logic [3:0] StLflush = 4'd2;
  localparam logic [3:0] StRat    = 4'd3;
  localparam logic [3:0] StWreq   = 4'd4;
  localparam logic [3:0] StWload  = 4'd5;
  localparam logic [3:0] StWflush = 4'd6;
  localparam logic [3:0] StDrain  = 4'd7;
  localparam logic [3:0] StClear  = 4'd8;

  logic [3:0]      state_q, state_d;
  logic [PhW-1:0]  ph_q, ph_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] w_q, w_d;
  logic            err_q, err_d;

  logic in_ok;
  logic load_beat;
  logic w_beat;
  logic last_in;
  logic last_w;
  logic row_end;
  logic col_end;

  // Beat qualification: beats outside their legal window are dropped and flagged.
  always_comb begin
    in_ok     = (state_q == StIdle) || (state_q == StLoad);
    load_beat = i_valid && in_ok;
    w_beat    = w_valid && (state_q == StWload);
    col_end   = (col_q == ColW'(COLS - 1));
    row_end   = (row_q == RowW'(ROWS - 1));
    last_in   = load_beat && row_end && col_end;
    last_w    = w_beat && (w_q == RowW'(ROWS - 1));
    // One pulse covers an illegal i_valid, an illegal w_valid, or both at once.
    err_d     = (i_valid && !in_ok) || (w_valid && (state_q != StWload));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StLoad: begin
        if (last_in) begin
          state_d = StLflush;
        end else if (load_beat) begin
          state_d = StLoad;
        end
      end
      StLflush: if (ph_q == PhW'(PIPE_LAT - 1)) state_d = StRat;
      StRat:    state_d = StWreq;
      StWreq:   state_d = StWload;
      StWload:  if (last_w) state_d = StWflush;
      StWflush: if (ph_q == PhW'(PIPE_LAT - 1)) state_d = StDrain;
      StDrain:  if (ph_q == PhW'(ROWS - 1)) state_d = StClear;
      StClear:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Phase counter restarts on every state change, so DRAIN sees 0..ROWS-1.
  always_comb begin
    ph_d = '0;
    if ((state_d == state_q) &&
        ((state_q == StLflush) || (state_q == StWflush) || (state_q == StDrain))) begin
      ph_d = ph_q + PhW'(1);
    end
  end

  // Input beat counter as row/column pair; cleared in CLEAR so IDLE always
  // starts a frame from beat 0.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (state_q == StClear) begin
      row_d = '0;
      col_d = '0;
    end else if (load_beat) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Weight beat counter
  always_comb begin
    w_d = w_q;
    if (state_q == StClear) begin
      w_d = '0;
    end else if (w_beat) begin
      w_d = last_w ? '0 : w_q + RowW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ph_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      w_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      row_q   <= row_d;
      col_q   <= col_d;
      w_q     <= w_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode registered state; only load/acc enables follow the beat inputs.
  always_comb begin
    dp_load_en = load_beat;
    dp_row_idx = row_q;
    dp_col_idx = col_q;
    dp_rat_en  = (state_q == StRat);
    w_ready    = (state_q == StWreq);
    dp_acc_clr = (state_q == StWreq);
    dp_acc_en  = w_beat;
    dp_w_idx   = w_q;
    o_valid    = (state_q == StDrain);
    dp_out_idx = o_valid ? ph_q[RowW-1:0] : '0;
    dp_clear   = (state_q == StClear);
    frame_done = (state_q == StClear);
    err_beat   = err_q;
  end

endmodule
